// File: rtl/jts18_pkg.sv
// Shared jts18 definitions: mixer state encoding, delay limits and small helpers.
package jts18_pkg;

    localparam int unsigned DLY_MIN = 1;
    localparam int unsigned DLY_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LINE = 2'd1,
        ST_HBL  = 2'd2
    } mix_st_e;

    // Everything that must travel through the alignment delay together
    typedef struct packed {
        logic       lvbl;
        logic       lhbl;
        logic [8:0] rgb;
        logic [11:0] pxl;
    } mix_bus_t;

    // Out-of-range delays are pulled back into the supported window
    function automatic int unsigned clamp_dly(input int unsigned d);
        if (d < DLY_MIN) return DLY_MIN;
        if (d > DLY_MAX) return DLY_MAX;
        return d;
    endfunction

    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/jts18_vdp_mix_dly.sv
// Parameterised-width shift register delaying a bus by DEPTH clk cycles.
module jts18_vdp_mix_dly #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 2
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [DEPTH-1:0][W-1:0] sr_q;

    // NOTE: the stages are plain flops, so clearing them on reset is cheap and keeps stale pixels from leaking out after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/jts18_vdp_mix.sv
// Selects between the System 16 palette index and the VDP colour per pixel,
// and measures how many VDP pixels each complete line showed.
module jts18_vdp_mix
    import jts18_pkg::*;
#(
    parameter int unsigned DLY   = 2,
    parameter logic [11:0] BLANK = 12'h000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic [11:0] s16_pxl,
    input  logic [8:0]  vdp_rgb,
    input  logic        vdp_sel,
    input  logic        vdp_en,
    input  logic [7:0]  debug_bus,
    output logic [11:0] pxl_out,
    output logic        src,
    output logic        LHBL_dly,
    output logic        LVBL_dly,
    output logic [7:0]  st_show
);

    localparam int unsigned DEPTH = clamp_dly(DLY);

    mix_bus_t    bus_in, bus_dly;
    mix_st_e     st_q;
    logic [11:0] pxl_out_q, pxl_d;
    logic        src_q, src_d;
    logic        lhbl_q, lvbl_q;
    logic        active_q, active_d;
    logic [8:0]  cnt_q, cnt_inc;
    logic [7:0]  show_q;
    logic        blank;
    logic        unused_dbg;

    assign bus_in     = '{lvbl: LVBL, lhbl: LHBL, rgb: vdp_rgb, pxl: s16_pxl};
    assign unused_dbg = ^debug_bus[7:2];

    jts18_vdp_mix_dly #(.W($bits(mix_bus_t)), .DEPTH(DEPTH)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .din_i  (bus_in),
        .dout_o (bus_dly)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        blank    = ~(bus_dly.lhbl & bus_dly.lvbl);
        active_d = active_q;
        if (lvbl_q && !bus_dly.lvbl) active_d = vdp_en;
        src_d = active_q & vdp_sel;
        if (debug_bus[1]) src_d = 1'b1;
        if (debug_bus[0]) src_d = 1'b0;
        if (blank)        src_d = 1'b0;
        pxl_d   = blank ? BLANK : (src_d ? {3'b000, bus_dly.rgb} : bus_dly.pxl);
        cnt_inc = (src_d && cnt_q != '1) ? cnt_q + 9'd1 : cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxl_out_q <= BLANK;
            src_q     <= 1'b0;
            lhbl_q    <= 1'b0;
            lvbl_q    <= 1'b0;
            active_q  <= 1'b0;
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            show_q    <= '0;
        end else if (pxl_cen) begin
            pxl_out_q <= pxl_d;
            src_q     <= src_d;
            lhbl_q    <= bus_dly.lhbl;
            lvbl_q    <= bus_dly.lvbl;
            active_q  <= active_d;
            if (!bus_dly.lvbl) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
            end else begin
                case (st_q)
                    // Vertical blanking may end inside a horizontal blank
                    ST_IDLE: begin
                        st_q  <= bus_dly.lhbl ? ST_LINE : ST_HBL;
                        cnt_q <= cnt_inc;
                    end
                    ST_LINE: begin
                        if (!bus_dly.lhbl) begin
                            st_q   <= ST_HBL;
                            show_q <= sat8(cnt_q);
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ST_HBL: begin
                        if (bus_dly.lhbl) begin
                            st_q  <= ST_LINE;
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        st_q  <= ST_IDLE;
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign pxl_out  = pxl_out_q;
    assign src      = src_q;
    assign LHBL_dly = lhbl_q;
    assign LVBL_dly = lvbl_q;
    assign st_show  = show_q;

endmodule

// File: tb/tb_jts18_vdp_mix.sv
// Randomised frame stimulus for jts18_vdp_mix checked against a per-pixel behavioural model.
module tb_jts18_vdp_mix;

    localparam logic [11:0] BLANK = 12'h000;

    logic        clk = 1'b0;
    logic        rst, pxl_cen, LHBL, LVBL, vdp_sel, vdp_en;
    logic [11:0] s16_pxl;
    logic [8:0]  vdp_rgb;
    logic [7:0]  debug_bus;
    logic [11:0] pxl_out;
    logic        src, LHBL_dly, LVBL_dly;
    logic [7:0]  st_show;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_active, m_prev_lvbl, m_in_line;
    int m_cnt, m_show;
    int src_ones;

    jts18_vdp_mix #(.DLY(2), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .s16_pxl(s16_pxl), .vdp_rgb(vdp_rgb), .vdp_sel(vdp_sel), .vdp_en(vdp_en),
        .debug_bus(debug_bus), .pxl_out(pxl_out), .src(src),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .st_show(st_show)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_prev_lvbl = 1'b0;
        m_in_line   = 1'b0;
        m_cnt       = 0;
        m_show      = 0;
    endtask

    // One pixel: inputs held for three clk, pxl_cen on the third (after the 2-clk alignment)
    task automatic px(input logic hb, input logic vb, input logic [11:0] s16,
                      input logic [8:0] rgb, input logic sel);
        logic [11:0] e_pxl;
        logic        e_src;
        LHBL = hb; LVBL = vb; s16_pxl = s16; vdp_rgb = rgb; vdp_sel = sel; pxl_cen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;

        if (m_prev_lvbl && !vb) m_active = vdp_en;
        m_prev_lvbl = vb;
        if (!(hb && vb))        e_src = 1'b0;
        else if (debug_bus[0])  e_src = 1'b0;
        else if (debug_bus[1])  e_src = 1'b1;
        else                    e_src = m_active && sel;
        e_pxl = !(hb && vb) ? BLANK : (e_src ? {3'b000, rgb} : s16);
        if (!vb) begin
            m_cnt = 0; m_in_line = 1'b0;
        end else if (hb) begin
            m_in_line = 1'b1;
            if (e_src && m_cnt < 511) m_cnt++;
        end else begin
            if (m_in_line) m_show = (m_cnt > 255) ? 255 : m_cnt;
            m_cnt = 0; m_in_line = 1'b0;
        end

        if (src === 1'b1) src_ones++;
        check("pxl_out",  pxl_out,  e_pxl);
        check("src",      {11'd0, src},      {11'd0, e_src});
        check("LHBL_dly", {11'd0, LHBL_dly}, {11'd0, hb});
        check("LVBL_dly", {11'd0, LVBL_dly}, {11'd0, vb});
        check("st_show",  {4'd0, st_show},   m_show[11:0]);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) px(1'($urandom), 1'b0, 12'hABC, 9'($urandom), 1'b1);
    endtask

    // mode 0: sel=0, 1: sel=1, 2: random, 3: first k selected, 4: lone pixel k with rgb 1FF
    task automatic line(input int n, input int mode, input int k, input bit with_hbl);
        logic       sel;
        logic [8:0] rgb;
        src_ones = 0;
        for (int i = 0; i < n; i++) begin
            rgb = 9'($urandom);
            case (mode)
                0:       sel = 1'b0;
                1:       sel = 1'b1;
                3:       sel = (i < k);
                4:       begin sel = (i == k); if (i == k) rgb = 9'h1FF; end
                default: sel = 1'($urandom);
            endcase
            px(1'b1, 1'b1, 12'($urandom), rgb, sel);
        end
        if (with_hbl) begin
            for (int i = 0; i < 6; i++) px(1'b0, 1'b1, 12'hABC, 9'($urandom), 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0; vdp_sel = 1'b0;
        vdp_en = 1'b0; s16_pxl = '0; vdp_rgb = '0; debug_bus = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pxl_out", pxl_out, BLANK);
        check("rst_src", {11'd0, src}, 12'd0);
        check("rst_st_show", {4'd0, st_show}, 12'd0);
        rst = 1'b0;

        // VDP stays off after reset, and enabling mid-frame waits for the next frame
        vblank(4);
        line(20, 1, 0, 1);
        vdp_en = 1'b1;
        line(20, 1, 0, 1);
        check("en_midframe_no_src", 12'(src_ones), 12'd0);
        vblank(4);
        line(20, 1, 0, 1);
        check("en_after_vbl_src", 12'(src_ones), 12'd20);

        // Lone selected pixel
        line(30, 4, 5, 1);
        check("lone_px_count", 12'(src_ones), 12'd1);
        check("lone_st_show", {4'd0, st_show}, 12'd1);

        // Saturating line count and a 17-pixel line
        line(320, 1, 0, 1);
        check("st_show_sat", {4'd0, st_show}, 12'd255);
        line(40, 3, 17, 1);
        check("st_show_17", {4'd0, st_show}, 12'd17);
        line(60, 2, 0, 1);

        // Debug overrides
        debug_bus = 8'h03;
        line(25, 1, 0, 1);
        check("dbg03_src", 12'(src_ones), 12'd0);
        debug_bus = 8'h02;
        line(25, 0, 0, 1);
        check("dbg02_src", 12'(src_ones), 12'd25);
        debug_bus = 8'h01;
        line(25, 1, 0, 1);
        debug_bus = 8'h00;

        // Partial line cut by vertical blank keeps the previous st_show
        line(33, 2, 0, 0);
        vblank(5);
        line(50, 2, 0, 1);

        // Disabling before a vertical blank turns the VDP off for the next frame
        vdp_en = 1'b0;
        vblank(4);
        line(20, 1, 0, 1);
        check("en_off_src", 12'(src_ones), 12'd0);
        vdp_en = 1'b1;
        vblank(4);
        line(20, 2, 0, 1);

        // Asynchronous reset in the middle of a line
        line(10, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_pxl_out", pxl_out, BLANK);
        check("midrst_src", {11'd0, src}, 12'd0);
        check("midrst_lhbl", {11'd0, LHBL_dly}, 12'd0);
        check("midrst_lvbl", {11'd0, LVBL_dly}, 12'd0);
        check("midrst_st_show", {4'd0, st_show}, 12'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        line(20, 1, 0, 1);
        check("post_rst_no_src", 12'(src_ones), 12'd0);
        vblank(4);
        line(20, 1, 0, 1);
        check("post_rst_vbl_src", 12'(src_ones), 12'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
